// File: rtl/sub_intn_seq_pkg.sv
// Shared definitions for the chunked sequential subtractor: mode encoding and FSM states.
package sub_intn_seq_pkg;

  localparam logic [1:0] SUB_WRAP = 2'd0;
  localparam logic [1:0] SUB_USAT = 2'd1;
  localparam logic [1:0] SUB_SSAT = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sub_state_t;

endpackage

// File: rtl/sub_intn_seq_chunk.sv
// Combinational CHUNK-bit subtractor slice with borrow-in and borrow-out.
module sub_chunk #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             b_in,
  output logic [CHUNK-1:0] d,
  output logic             b_out
);

  // One extra bit on top catches the borrow as the sign of the widened difference.
  always_comb begin
    {b_out, d} = {1'b0, a} - {1'b0, b} - (CHUNK + 1)'(b_in);
  end

endmodule

// File: rtl/sub_intn_seq.sv
// Multi-cycle subtractor: D = A - B one CHUNK-bit slice per clock, LSB first,
// with a registered borrow and wrap / unsigned-saturate / signed-saturate output.
module sub_intn_seq
  import sub_intn_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sub,
  output logic             borrow,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};

  sub_state_t       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic             bor_reg;
  logic [1:0]       mode_reg;
  logic             a_msb_reg;
  logic             b_msb_reg;

  logic [CHUNK-1:0] d_slice;
  logic             b_out;
  logic [WIDTH-1:0] res_next;
  logic             fin_ovf;
  logic [WIDTH-1:0] fin_sub;

  // Single slice subtractor, fed each cycle with the low bits of the shift registers.
  sub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a     (a_reg[CHUNK-1:0]),
    .b     (b_reg[CHUNK-1:0]),
    .b_in  (bor_reg),
    .d     (d_slice),
    .b_out (b_out)
  );

  // Next partial result and, on the last slice, the flags and mode-selected output.
  always_comb begin
    res_next = WIDTH'({d_slice, res_reg} >> CHUNK);
    fin_ovf  = (a_msb_reg != b_msb_reg) && (res_next[WIDTH-1] != a_msb_reg);
    case (mode_reg)
      SUB_WRAP: fin_sub = res_next;
      SUB_USAT: fin_sub = b_out ? '0 : res_next;
      SUB_SSAT: fin_sub = fin_ovf ? (a_msb_reg ? SMIN : SMAX) : res_next;
      default:  fin_sub = res_next;
    endcase
  end

  // Control FSM with shift registers and registered handshake/result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      bor_reg   <= 1'b0;
      mode_reg  <= '0;
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      Sub       <= '0;
      borrow    <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            a_reg     <= A;
            b_reg     <= B;
            mode_reg  <= mode;
            a_msb_reg <= A[WIDTH-1];
            b_msb_reg <= B[WIDTH-1];
            res_reg   <= '0;
            bor_reg   <= 1'b0;
            cnt_reg   <= '0;
            in_ready  <= 1'b0;
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_reg   <= a_reg >> CHUNK;
          b_reg   <= b_reg >> CHUNK;
          res_reg <= res_next;
          bor_reg <= b_out;
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_LAST) begin
            Sub       <= fin_sub;
            borrow    <= b_out;
            ovf       <= fin_ovf;
            out_valid <= 1'b1;
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub_intn_seq.sv
// Randomised self-checking bench: four WIDTH=8 instances (CHUNK 1,2,4,8) plus
// WIDTH=16/CHUNK=4, checked against an integer-arithmetic reference model.
module tb_sub_intn_seq;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] a_drv;
  logic [15:0] b_drv;
  logic [1:0]  mode_drv;
  logic        out_ready;
  logic [4:0]  in_valid_v;
  logic [4:0]  in_ready_v;
  logic [4:0]  out_valid_v;
  logic [4:0]  borrow_v;
  logic [4:0]  ovf_v;
  logic [7:0]  sub8 [4];
  logic [15:0] sub16;

  int n_cmp = 0;
  int n_bad = 0;

  logic [2:0]  cur;
  logic [15:0] sel_sub;
  logic        sel_ir, sel_ov, sel_bor, sel_ovf;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_w8
      sub_intn_seq #(.WIDTH(8), .CHUNK(1 << gi)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_v[gi]),
        .in_ready  (in_ready_v[gi]),
        .A         (a_drv[7:0]),
        .B         (b_drv[7:0]),
        .mode      (mode_drv),
        .out_valid (out_valid_v[gi]),
        .out_ready (out_ready),
        .Sub       (sub8[gi]),
        .borrow    (borrow_v[gi]),
        .ovf       (ovf_v[gi])
      );
    end
  endgenerate

  sub_intn_seq #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid_v[4]),
    .in_ready  (in_ready_v[4]),
    .A         (a_drv),
    .B         (b_drv),
    .mode      (mode_drv),
    .out_valid (out_valid_v[4]),
    .out_ready (out_ready),
    .Sub       (sub16),
    .borrow    (borrow_v[4]),
    .ovf       (ovf_v[4])
  );

  // Route the currently selected instance to a common observation point.
  always_comb begin
    sel_sub = (cur == 3'd4) ? sub16 : {8'h00, sub8[cur[1:0]]};
    sel_ir  = in_ready_v[cur];
    sel_ov  = out_valid_v[cur];
    sel_bor = borrow_v[cur];
    sel_ovf = ovf_v[cur];
  end

  function automatic int cfg_width(input int c);
    return (c == 4) ? 16 : 8;
  endfunction

  function automatic int cfg_nchunk(input int c);
    return (c == 4) ? 4 : (8 >> c);
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic logic [17:0] ref_model(input int w, input logic [15:0] a,
                                            input logic [15:0] b, input logic [1:0] m);
    longint md, ua, ub, sa, sb, diff;
    logic   brw, ov;
    logic [15:0] res;
    md   = longint'(1) << w;
    ua   = longint'(a) % md;
    ub   = longint'(b) % md;
    sa   = (ua >= md / 2) ? ua - md : ua;
    sb   = (ub >= md / 2) ? ub - md : ub;
    brw  = (ua < ub);
    diff = sa - sb;
    ov   = (diff > md / 2 - 1) || (diff < -(md / 2));
    res  = 16'((ua - ub + md) % md);
    if (m == 2'd1 && brw) res = 16'(0);
    else if (m == 2'd2 && ov) res = (diff < 0) ? 16'(md / 2) : 16'(md / 2 - 1);
    return {brw, ov, res};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cfg %0d)", tag, got, exp, cur);
    end
  endtask

  function automatic logic [15:0] pick_op(input int w);
    logic [15:0] mask;
    logic [15:0] half;
    int r;
    mask = (w == 16) ? 16'hFFFF : 16'h00FF;
    half = (w == 16) ? 16'h8000 : 16'h0080;
    r = int'($urandom_range(0, 6));
    case (r)
      0:       return 16'h0000;
      1:       return mask;
      2:       return half;
      3:       return half - 16'h1;
      default: return 16'($urandom) & mask;
    endcase
  endfunction

  // One full transaction: accept, latency, result, backpressure, handshake.
  task automatic run_txn(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] m, input int hold);
    logic [17:0] exp;
    int lat;
    cur = c;
    exp = ref_model(cfg_width(c), a, b, m);
    @(negedge clk);
    lat = 0;
    while (!sel_ir && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("ready_before", 32'(sel_ir), 32'd1);
    a_drv = a; b_drv = b; mode_drv = m;
    in_valid_v[c] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Scramble pins and keep in_valid high: nothing after the accept may be consumed.
    a_drv = 16'($urandom); b_drv = 16'($urandom); mode_drv = 2'($urandom);
    lat = 0;
    while (!sel_ov && lat < 64) begin
      chk("busy_ready", 32'(sel_ir), 32'd0);
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(cfg_nchunk(c)));
    chk("sub", 32'(sel_sub), 32'(exp[15:0]));
    chk("borrow", 32'(sel_bor), 32'(exp[17]));
    chk("ovf", 32'(sel_ovf), 32'(exp[16]));
    for (int i = 0; i < hold; i++) begin
      a_drv = 16'($urandom); b_drv = 16'($urandom);
      @(negedge clk);
      chk("hold_valid", 32'(sel_ov), 32'd1);
      chk("hold_ready", 32'(sel_ir), 32'd0);
      chk("hold_sub", 32'(sel_sub), 32'(exp[15:0]));
      chk("hold_flags", 32'({sel_bor, sel_ovf}), 32'(exp[17:16]));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_valid", 32'(sel_ov), 32'd0);
    chk("post_ready", 32'(sel_ir), 32'd1);
    chk("post_sub", 32'(sel_sub), 32'(exp[15:0]));
    in_valid_v[c] = 1'b0;
    $display("txn cfg=%0d A=0x%0h B=0x%0h mode=%0d -> Sub=0x%0h borrow=%0b ovf=%0b lat=%0d",
             c, a, b, m, sel_sub, sel_bor, sel_ovf, lat);
  endtask

  initial begin
    rst = 1'b1; in_valid_v = '0; out_ready = 1'b0;
    a_drv = '0; b_drv = '0; mode_drv = '0; cur = 3'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cur = 3'(c);
      #1;
      chk("rst_ready", 32'(sel_ir), 32'd1);
      chk("rst_valid", 32'(sel_ov), 32'd0);
      chk("rst_out", 32'({sel_sub, sel_bor, sel_ovf}), 32'd0);
    end

    // Directed cases on WIDTH=8, CHUNK=2.
    run_txn(3'd1, 16'h05, 16'h03, 2'd0, 0);
    run_txn(3'd1, 16'h03, 16'h05, 2'd0, 0);
    run_txn(3'd1, 16'h03, 16'h05, 2'd1, 0);
    run_txn(3'd1, 16'h80, 16'h01, 2'd2, 0);
    run_txn(3'd1, 16'h7F, 16'hFF, 2'd2, 0);
    run_txn(3'd1, 16'h80, 16'h01, 2'd0, 0);
    run_txn(3'd1, 16'h7F, 16'hFF, 2'd0, 10);
    run_txn(3'd1, 16'h05, 16'h09, 2'd3, 2);

    // Reset in the middle of RUN discards the transaction.
    cur = 3'd1;
    @(negedge clk);
    a_drv = 16'h55; b_drv = 16'h0F; mode_drv = 2'd0;
    in_valid_v[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_v[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_valid", 32'(sel_ov), 32'd0);
    chk("midrst_ready", 32'(sel_ir), 32'd1);
    chk("midrst_out", 32'({sel_sub, sel_bor, sel_ovf}), 32'd0);
    repeat (6) @(negedge clk);
    chk("midrst_quiet", 32'(sel_ov), 32'd0);
    run_txn(3'd1, 16'h10, 16'h01, 2'd0, 0);

    // Random sweep across all configurations.
    for (int c = 0; c < 5; c++) begin
      for (int k = 0; k < 20; k++) begin
        run_txn(3'(c), pick_op(cfg_width(c)), pick_op(cfg_width(c)),
                2'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
